// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding and shared constants for sram_mem_controller.
// Contents: state_t (controller states), DEFAULT_BASE_ADDR (CPU byte address
// of SRAM halfword 0), HW_LO/HW_HI (halfword select bit of sram_addr).
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam logic        HW_LO             = 1'b0;
    localparam logic        HW_HI             = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: times one SRAM halfword phase of WAIT_CYCLES+1 cycles.
// Ports: clk, rst (async, active-high); load restarts the count at 0;
// en advances it; last is high while the count equals WAIT_CYCLES.
module sram_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);

    logic [3:0] count_q, count_d;

    assign count_d = load ? 4'd0 : en ? count_q + 4'd1 : count_q;
    assign last    = count_q == 4'(WAIT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= 4'd0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: services 32-bit MEM-stage loads/stores over a 16-bit
// SRAM as two halfword phases, holding ready low while an access runs.
// Ports: clk, rst (async, active-high); MEM_R_EN/MEM_W_EN level requests;
// addr/wdata request operands; rdata load result; ready pipeline advance;
// sram_addr/sram_dq_out/sram_dq_in/sram_dq_oe/sram_we_n SRAM pins.
// Option: define SRAM_LAST_READ_BUF_EN for a one-entry last-read buffer.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int WW = SRAM_AW - 1;

    state_t             state_q, state_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d, wdata_hi_q, wdata_hi_d;
    logic               oe_q, oe_d, we_n_q, we_n_d;
    logic [WW-1:0]      word;
    logic               phase, last;

    // Word index wraps modulo the SRAM size, so addresses below BASE_ADDR alias.
    assign word  = WW'((addr - BASE_ADDR) >> 2);
    assign phase = state_q inside {RD_LO, RD_HI, WR_LO, WR_HI};

    // Counter restarts whenever a phase is entered and only counts inside phases.
    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (!phase || last),
        .en   (phase),
        .last (last)
    );

`ifdef SRAM_LAST_READ_BUF_EN
    logic          buf_valid_q, buf_valid_d, fill_q, fill_d, hit;
    logic [WW-1:0] buf_word_q, buf_word_d;
    logic [31:0]   buf_data_q, buf_data_d;

    assign hit = buf_valid_q && buf_word_q == word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            fill_q      <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            fill_q      <= fill_d;
            buf_word_q  <= buf_word_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        wdata_hi_d  = wdata_hi_q;
        oe_d        = oe_q;
        we_n_d      = we_n_q;
`ifdef SRAM_LAST_READ_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_word_d  = buf_word_q;
        buf_data_d  = buf_data_q;
        fill_d      = fill_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef SRAM_LAST_READ_BUF_EN
                fill_d = MEM_R_EN && !MEM_W_EN && !hit;
                if (MEM_W_EN && hit) buf_data_d = wdata;
`endif
                if (MEM_W_EN) begin
                    state_d     = WR_LO;
                    sram_addr_d = {word, HW_LO};
                    dq_out_d    = wdata[15:0];
                    wdata_hi_d  = wdata[31:16];
                    oe_d        = 1'b1;
                    we_n_d      = 1'b0;
                end
`ifdef SRAM_LAST_READ_BUF_EN
                else if (MEM_R_EN && hit) begin
                    state_d = DONE;
                    rdata_d = buf_data_q;
                end
`endif
                else if (MEM_R_EN) begin
                    state_d     = RD_LO;
                    sram_addr_d = {word, HW_LO};
                end
            end
            RD_LO: if (last) begin
                rdata_d[15:0] = sram_dq_in;
                state_d       = RD_HI;
                sram_addr_d   = {sram_addr_q[SRAM_AW-1:1], HW_HI};
            end
            RD_HI: if (last) begin
                rdata_d[31:16] = sram_dq_in;
                state_d        = DONE;
            end
            WR_LO: if (last) begin
                state_d     = WR_HI;
                sram_addr_d = {sram_addr_q[SRAM_AW-1:1], HW_HI};
                dq_out_d    = wdata_hi_q;
            end
            WR_HI: if (last) begin
                state_d = DONE;
                oe_d    = 1'b0;
                we_n_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
`ifdef SRAM_LAST_READ_BUF_EN
                // sram_addr still holds the HI halfword of the word just read.
                if (fill_q) begin
                    buf_valid_d = 1'b1;
                    buf_word_d  = sram_addr_q[SRAM_AW-1:1];
                    buf_data_d  = rdata_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            wdata_hi_q  <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            wdata_hi_q  <= wdata_hi_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = (state_q == IDLE && !MEM_R_EN && !MEM_W_EN) || state_q == DONE;
    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: randomized self-checking bench for sram_mem_controller.
module tb_sram_mem_controller;

    localparam int W    = 2;
    localparam int FULL = 2 * (W + 1) + 1;

    logic        clk = 1'b0, rst = 1'b1, r_en = 1'b0, w_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        pre_en = 1'b0;
    logic [17:0] pre_a = '0;
    logic [15:0] pre_d = '0;
    logic [15:0] sram [0:262143];
    logic [31:0] ref_words [int];
    logic [31:0] exp_rdata = '0;
    int          checks = 0, failures = 0;
    int          obs_lat, obs_lo, obs_hi, obs_we, obs_wdok, obs_oe;
    logic        obs_moved, obs_done_we_n, obs_done_oe;
`ifdef SRAM_LAST_READ_BUF_EN
    bit          mb_valid = 1'b0;
    int          mb_idx = 0;
`endif

    always #5 clk = ~clk;

    assign sram_dq_in = sram[sram_addr];

    always @(posedge clk) begin
        if (pre_en) sram[pre_a] <= pre_d;
        else if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    end

    sram_mem_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    function automatic int widx(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) % 32'h20000);
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Drives one request starting in the current cycle and records what the SRAM side saw.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit scramble, input bit hold);
        logic [17:0] a0, lo, hi;
        int idx;
        idx = widx(a);
        lo = 18'(idx * 2);
        hi = lo + 18'd1;
        r_en = r; w_en = w; addr = a; wdata = d;
        a0 = sram_addr;
        obs_lat = -1; obs_lo = 0; obs_hi = 0; obs_we = 0; obs_wdok = 0; obs_oe = 0;
        obs_moved = 1'b0; obs_done_we_n = 1'b0; obs_done_oe = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sram_addr !== a0) obs_moved = 1'b1;
            if (ready) begin
                obs_lat = n; obs_done_we_n = sram_we_n; obs_done_oe = sram_dq_oe;
                break;
            end
            if (n > 0) begin
                if (sram_addr == lo) obs_lo++;
                if (sram_addr == hi) obs_hi++;
                if (!sram_we_n) obs_we++;
                if (sram_dq_oe) obs_oe++;
                if (!sram_we_n && sram_dq_oe && ((sram_addr == lo && sram_dq_out == d[15:0]) ||
                    (sram_addr == hi && sram_dq_out == d[31:16]))) obs_wdok++;
            end
            @(posedge clk); #1;
            if (scramble && n == 0) begin
                addr = $urandom; wdata = $urandom;
                if ($urandom_range(1) == 1) begin r_en = 1'b0; w_en = 1'b0; end
            end
        end
        @(posedge clk); #1;
        if (!hold) begin r_en = 1'b0; w_en = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if ({sram_we_n, sram_dq_oe} !== 2'b10) begin failures++; $display("FAIL reset_we_oe got=%b exp=10", {sram_we_n, sram_dq_oe}); end
        checks++; if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin failures++; $display("FAIL reset_pins got=%h/%h exp=0/0", sram_addr, sram_dq_out); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read();
        preload(18'd4, 16'hBEEF);
        preload(18'd5, 16'hDEAD);
        ref_words[2] = 32'hDEADBEEF;
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_lat !== 7) begin failures++; $display("FAIL read_latency got=%0d exp=7", obs_lat); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", rdata); end
        checks++; if (obs_lo !== 3 || obs_hi !== 3) begin failures++; $display("FAIL read_addr_seq got=%0d/%0d exp=3/3", obs_lo, obs_hi); end
        checks++; if (obs_we !== 0 || obs_oe !== 0 || obs_done_we_n !== 1'b1) begin failures++; $display("FAIL read_no_write got=we%0d oe%0d exp=0", obs_we, obs_oe); end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0, 1'b0);
        checks++; if (obs_lat !== 7) begin failures++; $display("FAIL write_latency got=%0d exp=7", obs_lat); end
        checks++; if (obs_we !== 6 || obs_wdok !== 6 || obs_lo !== 3 || obs_hi !== 3) begin failures++; $display("FAIL write_phases got=we%0d ok%0d lo%0d hi%0d exp=6/6/3/3", obs_we, obs_wdok, obs_lo, obs_hi); end
        checks++; if (sram[2] !== 16'h5678 || sram[3] !== 16'h1234) begin failures++; $display("FAIL write_sram got=%h_%h exp=1234_5678", sram[3], sram[2]); end
        checks++; if (obs_done_we_n !== 1'b1 || obs_done_oe !== 1'b0) begin failures++; $display("FAIL write_done_pins got=%b%b exp=10", obs_done_we_n, obs_done_oe); end
        checks++; if (rdata !== exp_rdata) begin failures++; $display("FAIL write_rdata_held got=%h exp=%h", rdata, exp_rdata); end
        ref_words[1] = 32'h12345678;
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_lat !== 7 || rdata !== 32'h12345678) begin failures++; $display("FAIL write_readback got=%h lat%0d exp=12345678 lat7", rdata, obs_lat); end
        exp_rdata = 32'h12345678;
    endtask

    task automatic test_both_high();
        access(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 1'b0, 1'b0);
        checks++; if (obs_lat !== 7 || obs_we !== 6) begin failures++; $display("FAIL both_write got=lat%0d we%0d exp=7/6", obs_lat, obs_we); end
        checks++; if (sram[0] !== 16'hA5A5 || sram[1] !== 16'hA5A5) begin failures++; $display("FAIL both_sram got=%h_%h exp=a5a5_a5a5", sram[1], sram[0]); end
        checks++; if (rdata !== exp_rdata) begin failures++; $display("FAIL both_rdata got=%h exp=%h", rdata, exp_rdata); end
        ref_words[0] = 32'hA5A5A5A5;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            r_en = (k == 0); w_en = (k == 1);
            addr = (k == 0) ? 32'd1032 : 32'd4096; wdata = $urandom;
            repeat (5) @(posedge clk);
            #1;
            if (k == 1) begin
                checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL midwr_we_active got=%b exp=0", sram_we_n); end
            end
            rst = 1'b1; #1;
            checks++; if ({sram_we_n, sram_dq_oe} !== 2'b10) begin failures++; $display("FAIL mid_reset_we_oe k=%0d got=%b exp=10", k, {sram_we_n, sram_dq_oe}); end
            checks++; if (rdata !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin failures++; $display("FAIL mid_reset_regs k=%0d got=%h/%h/%h exp=0", k, rdata, sram_addr, sram_dq_out); end
            r_en = 1'b0; w_en = 1'b0; #1;
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_reset_idle k=%0d got=%b exp=1", k, ready); end
            @(posedge clk); #1;
            rst = 1'b0;
            exp_rdata = 32'h0;
        end
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_lat !== 7 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL post_reset_read got=%h lat%0d exp=deadbeef lat7", rdata, obs_lat); end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        access(1'b0, 1'b1, 32'd1040, d, 1'b0, 1'b0);
        ref_words[4] = d;
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1);
        checks++; if (obs_lat !== 7 || rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_first got=%h lat%0d exp=a5a5a5a5 lat7", rdata, obs_lat); end
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_lat !== 7 || rdata !== d) begin failures++; $display("FAIL b2b_second got=%h lat%0d exp=%h lat7", rdata, obs_lat, d); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", ready); end
        @(posedge clk); #1;
        exp_rdata = d;
    endtask

    task automatic test_buffer();
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b0);
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b0);
`ifdef SRAM_LAST_READ_BUF_EN
        checks++; if (obs_lat !== 1 || obs_moved !== 1'b0) begin failures++; $display("FAIL buf_hit got=lat%0d moved%b exp=1/0", obs_lat, obs_moved); end
`else
        checks++; if (obs_lat !== FULL || obs_lo !== 3) begin failures++; $display("FAIL nobuf_reread got=lat%0d lo%0d exp=%0d/3", obs_lat, obs_lo, FULL); end
`endif
        checks++; if (rdata !== ref_words[4]) begin failures++; $display("FAIL buf_reread_data got=%h exp=%h", rdata, ref_words[4]); end
        access(1'b0, 1'b1, 32'd1040, 32'h0000FFFF, 1'b0, 1'b0);
        ref_words[4] = 32'h0000FFFF;
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b0);
        checks++; if (rdata !== 32'h0000FFFF) begin failures++; $display("FAIL buf_after_write got=%h exp=0000ffff", rdata); end
`ifdef SRAM_LAST_READ_BUF_EN
        checks++; if (obs_lat !== 1 || obs_moved !== 1'b0) begin failures++; $display("FAIL buf_write_hit got=lat%0d moved%b exp=1/0", obs_lat, obs_moved); end
`else
        checks++; if (obs_lat !== FULL) begin failures++; $display("FAIL nobuf_latency got=%0d exp=%0d", obs_lat, FULL); end
`endif
        exp_rdata = 32'h0000FFFF;
    endtask

    task automatic test_random();
        logic [31:0] keys[$];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = 32'h0;
`ifdef SRAM_LAST_READ_BUF_EN
        mb_valid = 1'b0;
`endif
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, d;
            bit w, r;
            int idx, el;
            w = (keys.size() == 0) || ($urandom_range(2) == 0);
            r = w ? bit'($urandom_range(1)) : 1'b1;
            d = $urandom;
            if (w) a = $urandom;
            else begin
                a = (keys[$urandom_range(keys.size() - 1)] & ~32'h3) | 32'($urandom_range(3));
                a = a + (32'($urandom_range(7)) << 19);
            end
            idx = widx(a);
            el = FULL;
`ifdef SRAM_LAST_READ_BUF_EN
            if (!w) begin
                if (mb_valid && mb_idx == idx) el = 1;
                else begin mb_valid = 1'b1; mb_idx = idx; end
            end
`endif
            access(r, w, a, d, bit'($urandom_range(1)), 1'b0);
            checks++; if (obs_lat !== el) begin failures++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, obs_lat, el); end
            if (w) begin
                checks++; if (sram[2*idx] !== d[15:0] || sram[2*idx+1] !== d[31:16] || obs_wdok !== 6) begin failures++; $display("FAIL rand_write i=%0d got=%h_%h ok%0d exp=%h ok6", i, sram[2*idx+1], sram[2*idx], obs_wdok, d); end
                checks++; if (rdata !== exp_rdata) begin failures++; $display("FAIL rand_rdata_held i=%0d got=%h exp=%h", i, rdata, exp_rdata); end
                ref_words[idx] = d;
                keys.push_back(a);
            end else begin
                checks++; if (rdata !== ref_words[idx]) begin failures++; $display("FAIL rand_read i=%0d got=%h exp=%h", i, rdata, ref_words[idx]); end
                if (el == FULL) begin
                    checks++; if (obs_lo !== 3 || obs_hi !== 3 || obs_we !== 0) begin failures++; $display("FAIL rand_read_pins i=%0d got=lo%0d hi%0d we%0d exp=3/3/0", i, obs_lo, obs_hi, obs_we); end
                end else begin
                    checks++; if (obs_moved !== 1'b0) begin failures++; $display("FAIL rand_hit_quiet i=%0d got=%b exp=0", i, obs_moved); end
                end
                exp_rdata = ref_words[idx];
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_both_high();
        test_reset_mid();
        test_back_to_back();
        test_buffer();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
